// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
// Round-robin arbiter in front of a shared 4-way select path. One requester
// wins per transfer. Its word is registered into a single-entry output buffer
// that has a valid/ready handshake toward the consumer. No combinational path
// runs from the consumer back into the data of the producers. The only
// combinational feedback is out_ready gating gnt.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req[3:0]   request per requester (bit 0 = in1 ... bit 3 = in4)
//   in1..in4   requester data words, WIDTH bits each
//   gnt[3:0]   one-hot accept; the granted word is captured at this edge
//   sel[1:0]   mux code of the last accepted word (00=in1 ... 11=in4)
//   out_data   registered selected word
//   out_valid  out_data holds an unconsumed word
//   out_ready  consumer takes out_data this cycle
module mux4_rr_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    buf_state_t       state_p1;
    buf_state_t       state_nxt;
    logic [1:0]       ptr_p1;
    logic [1:0]       sel_p1;
    logic [WIDTH-1:0] data_p1;
    logic             vld_p1;

    logic [1:0]       win_p0;
    logic             load_p0;
    logic [WIDTH-1:0] word_p0;

    // Search starts at the pointer and walks upward modulo 4. The first set
    // request wins. The result is only meaningful when |r is true.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic       found;
        rr_pick = p;
        found   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = p + 2'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    // ---- stage p0: arbitration and select (combinational) ----
    assign vld_p1  = (state_p1 == FULL);
    assign load_p0 = (|req) && (!vld_p1 || out_ready);
    assign win_p0  = rr_pick(req, ptr_p1);

    always_comb begin
        word_p0 = in1;
        case (win_p0)
            2'd0:    word_p0 = in1;
            2'd1:    word_p0 = in2;
            2'd2:    word_p0 = in3;
            default: word_p0 = in4;
        endcase
    end

    // While reset is held, gnt is masked. Without the mask, req with an empty
    // buffer would still compute a load.
    always_comb begin
        gnt = 4'b0000;
        if (rst_n && load_p0) begin
            gnt[win_p0] = 1'b1;
        end
    end

    // A refill takes priority over a drain, so the buffer stays FULL when a
    // word is consumed and replaced on the same edge.
    always_comb begin
        state_nxt = state_p1;
        if (load_p0) begin
            state_nxt = FULL;
        end else if (vld_p1 && out_ready) begin
            state_nxt = EMPTY;
        end
    end

    // ---- stage p1: output buffer registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1 <= EMPTY;
            ptr_p1   <= 2'd0;
            sel_p1   <= 2'd0;
            data_p1  <= '0;
        end else begin
            state_p1 <= state_nxt;
            if (load_p0) begin
                data_p1 <= word_p0;
                sel_p1  <= win_p0;
                ptr_p1  <= win_p0 + 2'd1;
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign sel       = sel_p1;

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares one 4-way 32-bit select path between four requesters. Each requester presents a word and a request. The block picks one winner per transfer and drives the mux control code. It registers the selected word into a single-entry output buffer with a valid/ready handshake toward the consumer stage of the MIPS datapath, so the shared mux can serve four producers without combinational paths from consumer to producers.

## Interface
- WIDTH, 32, data width of each input word and of out_data
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  4  request per requester; bit 0 = in1, bit 3 = in4
- in1, in2, in3, in4  input  WIDTH  requester data words
- gnt  output  4  one-hot accept; gnt[i] high means in(i+1) is captured at this rising edge
- sel  output  2  registered mux control of the last accepted word; 00=in1, 01=in2, 10=in3, 11=in4
- out_data  output  WIDTH  registered selected word
- out_valid  output  1  out_data holds an unconsumed word
- out_ready  input  1  consumer accepts out_data this cycle

## Operation
- Buffer states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Round-robin pointer ptr (2 bits):
  - Indicates the highest-priority requester.
  - Search order is ptr, ptr+1, ptr+2, ptr+3, taken mod 4.
- load = (|req) && (!out_valid || out_ready).
  - This allows refill in the same cycle as drain.
- winner = the first index in search order with req set. It is only defined when |req is true.
- gnt = one-hot(winner) when load, otherwise 0000.
  - gnt is combinational from req, out_valid, out_ready and ptr.
  - gnt is forced to 0000 while rst_n is low.
- On a clock edge with load:
  - out_data ← word of winner.
  - sel ← winner.
  - ptr ← winner+1 mod 4, so index 3 wraps to 0.
  - out_valid ← 1.
- On a clock edge with out_valid && out_ready && !load: out_valid ← 0. out_data, sel and ptr hold.
- Otherwise all registers hold. In FULL with out_ready=0, out_data must not change, even if req or the in* inputs change.
- Requester obligation:
  - Hold req and its data stable until it sees gnt.
  - Deassert or present the next word in the cycle after gnt.
  - The arbiter never drops a granted word.
- Deasserting req before grant withdraws the request. No grant is issued for it.
- The arbiter never grants more than one requester per cycle, and never grants a requester whose req is 0.

## Timing
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, sel=00, ptr=00, gnt=0000.
  - Reset takes effect immediately, regardless of clk.
- Reset mid-transfer discards the buffered word. After release, operation restarts from ptr=00.
- Latency: req asserted in cycle N with the buffer EMPTY gives gnt in cycle N, and out_valid/out_data valid from cycle N+1.
- Throughput: one word per cycle when out_ready stays high and any req is present.
- Fairness: a continuously requesting input waits at most 3 grants before its own.
- Simultaneous drain and refill: a new word replaces the consumed one in the same edge, and out_valid stays 1.
- No requests while FULL and out_ready=1: the buffer goes EMPTY at the next edge.

## Test plan
- Reset: assert rst_n=0 mid-stream with out_valid=1 → out_valid, sel, gnt and out_data all drop to 0 without a clock edge. The first grant after release goes to in1 if all requesters are active.
- Single requester: req=0100, in3=32'hDEADBEEF, out_ready=1 → gnt=0100 in the same cycle. The next cycle shows out_data=32'hDEADBEEF, sel=10, out_valid=1.
- Full contention: req=1111, out_ready=1, in_k=k → grants cycle 0001, 0010, 0100, 1000, 0001. out_data follows 1, 2, 3, 4, 1 on consecutive cycles.
- Backpressure: the buffer is FULL with 32'hA5A5A5A5 and out_ready=0 for 5 cycles while req=1111 → gnt=0000, and out_data is stable throughout. Raising out_ready gives a grant in that cycle and the new word on the next edge.
- Pointer wrap and skip: after a grant to in4, set req=0101 → grant goes to in1 (ptr wrapped to 0). The next grant goes to in3, skipping in2.
- Drain to empty: one word is buffered, req=0000, out_ready=1 → out_valid goes 0 after one edge, and sel and out_data hold their last values.
